// File: rtl/inst_mem_fetch_arbiter.sv
// Round-robin arbiter sharing the LC3 instruction-memory port between the CPU fetch unit (req0)
// and the loader/debug reader (req1); one outstanding read, timeout returns err=1 with zero data.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   S_IDLE | no read in flight; winner gets combinational ready, accept starts a read
//   S_WAIT | instrmem_rd held with PC stable, timer counts until completion or timeout
//   S_RESP | one-cycle rsp_valid pulse to the owner, last_grant updated
module inst_mem_fetch_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_pc,
    output logic        req0_ready,
    output logic        req0_rsp_valid,
    output logic [15:0] req0_rsp_data,
    output logic        req0_rsp_err,
    input  logic        req1_valid,
    input  logic [15:0] req1_pc,
    output logic        req1_ready,
    output logic        req1_rsp_valid,
    output logic [15:0] req1_rsp_data,
    output logic        req1_rsp_err,
    output logic [15:0] PC,
    output logic        instrmem_rd,
    input  logic [15:0] instr_dout,
    input  logic        complete_instr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic       owner_q;
    logic       last_grant_q;
    logic [7:0] timer_q;
    logic       grant0, grant1, timeout;

    // On contention the requester that was not served last wins.
    assign grant0  = req0_valid && (!req1_valid || last_grant_q);
    assign grant1  = req1_valid && (!req0_valid || !last_grant_q);
    assign timeout = (timer_q == TIMER_LAST);

    always_comb begin
        state_d        = state_q;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        req0_rsp_valid = 1'b0;
        req1_rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (complete_instr)  state_d = S_RESP;
                else if (timeout)    state_d = S_RESP;
            end
            S_RESP: begin
                req0_rsp_valid = !owner_q;
                req1_rsp_valid = owner_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            timer_q       <= 8'd0;
            PC            <= 16'h0000;
            instrmem_rd   <= 1'b0;
            req0_rsp_data <= 16'h0000;
            req0_rsp_err  <= 1'b0;
            req1_rsp_data <= 16'h0000;
            req1_rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        owner_q     <= grant1;
                        PC          <= grant1 ? req1_pc : req0_pc;
                        instrmem_rd <= 1'b1;
                        timer_q     <= 8'd0;
                    end
                end
                S_WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    // Completion takes priority over a simultaneous timeout.
                    if (complete_instr) begin
                        instrmem_rd <= 1'b0;
                        if (owner_q) begin
                            req1_rsp_data <= instr_dout;
                            req1_rsp_err  <= 1'b0;
                        end else begin
                            req0_rsp_data <= instr_dout;
                            req0_rsp_err  <= 1'b0;
                        end
                    end else if (timeout) begin
                        instrmem_rd <= 1'b0;
                        if (owner_q) begin
                            req1_rsp_data <= 16'h0000;
                            req1_rsp_err  <= 1'b1;
                        end else begin
                            req0_rsp_data <= 16'h0000;
                            req0_rsp_err  <= 1'b1;
                        end
                    end
                end
                S_RESP: last_grant_q <= owner_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_fetch_arbiter.sv
// Randomized scoreboard bench for inst_mem_fetch_arbiter: two requester drivers, a memory
// responder whose latency and data are functions of the address, and a negedge monitor.
`timescale 1ns/1ps
module tb_inst_mem_fetch_arbiter;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_rsp_valid, req0_rsp_err;
    logic [15:0] req0_pc, req0_rsp_data;
    logic        req1_valid, req1_ready, req1_rsp_valid, req1_rsp_err;
    logic [15:0] req1_pc, req1_rsp_data;
    logic [15:0] PC, instr_dout;
    logic        instrmem_rd, complete_instr;

    always #5 clock = ~clock;

    inst_mem_fetch_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_ready(req0_ready),
        .req0_rsp_valid(req0_rsp_valid), .req0_rsp_data(req0_rsp_data), .req0_rsp_err(req0_rsp_err),
        .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_ready(req1_ready),
        .req1_rsp_valid(req1_rsp_valid), .req1_rsp_data(req1_rsp_data), .req1_rsp_err(req1_rsp_err),
        .PC(PC), .instrmem_rd(instrmem_rd), .instr_dout(instr_dout), .complete_instr(complete_instr)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int unsigned cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory contents and read latency (in WAIT cycles) are derived from the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], ~a[15:8]} ^ 16'h1261;
    endfunction

    function automatic int fetch_delay(input logic [15:0] a);
        return int'(a[4:0]) + 1;
    endfunction

    function automatic rsp_t expect_rsp(input logic [15:0] a);
        rsp_t r;
        if (fetch_delay(a) <= TMO) begin
            r.data = mem_word(a);
            r.err  = 1'b0;
        end else begin
            r.data = 16'h0000;
            r.err  = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory responder: completes after fetch_delay WAIT cycles, spurious pulses while idle.
    int rcnt = 0;
    initial begin
        complete_instr = 1'b0;
        instr_dout     = 16'h0000;
        forever begin
            @(posedge clock); #1;
            if (instrmem_rd) begin
                rcnt++;
                complete_instr = (rcnt == fetch_delay(PC));
                instr_dout     = complete_instr ? mem_word(PC) : 16'($urandom);
            end else begin
                rcnt           = 0;
                complete_instr = ($urandom_range(3) == 0);
                instr_dout     = 16'($urandom);
            end
        end
    end

    // Monitor: reference arbitration, port timing and scoreboard of responses.
    bit          m_busy = 1'b0;
    logic        m_owner = 1'b0;
    logic        m_lg = 1'b1;
    logic        m_e0, m_e1;
    int unsigned m_rsp_cyc = 0;
    logic [15:0] m_pc = 16'h0;
    rsp_t        m_r;

    always @(negedge clock) begin
        if (reset) begin
            m_busy = 1'b0;
            m_lg   = 1'b1;
        end else begin
            m_e0 = !m_busy && req0_valid && (!req1_valid || m_lg);
            m_e1 = !m_busy && req1_valid && (!req0_valid || !m_lg);
            check("req0_ready", req0_ready, m_e0);
            check("req1_ready", req1_ready, m_e1);
            check("instrmem_rd", instrmem_rd, m_busy && (cyc < m_rsp_cyc));
            if (instrmem_rd) check("PC", PC, m_pc);
            if (req0_rsp_valid || req1_rsp_valid) begin
                check("rsp_onehot", {req0_rsp_valid, req1_rsp_valid}, m_owner ? 2'b01 : 2'b10);
                check("rsp_in_flight", m_busy, 1);
                check("rsp_cycle", cyc, m_rsp_cyc);
                if (req1_rsp_valid) begin
                    check("rsp1_queue_nonempty", q1.size() > 0, 1);
                    if (q1.size() > 0) begin
                        m_r = q1.pop_front();
                        check("rsp1_data", req1_rsp_data, m_r.data);
                        check("rsp1_err", req1_rsp_err, m_r.err);
                    end
                end else begin
                    check("rsp0_queue_nonempty", q0.size() > 0, 1);
                    if (q0.size() > 0) begin
                        m_r = q0.pop_front();
                        check("rsp0_data", req0_rsp_data, m_r.data);
                        check("rsp0_err", req0_rsp_err, m_r.err);
                    end
                end
                m_busy = 1'b0;
                m_lg   = m_owner;
            end
            if (m_e0 || m_e1) begin
                m_busy    = 1'b1;
                m_owner   = m_e1;
                m_pc      = m_e1 ? req1_pc : req0_pc;
                m_rsp_cyc = cyc + 1 + ((fetch_delay(m_pc) < TMO) ? fetch_delay(m_pc) : TMO);
            end
        end
    end

    task automatic drive_req(input int id, input logic v, input logic [15:0] pc);
        if (id == 0) begin req0_valid = v; req0_pc = pc; end
        else         begin req1_valid = v; req1_pc = pc; end
    endtask

    function automatic logic get_ready(input int id);
        return (id == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic push_exp(input int id, input logic [15:0] pc);
        if (id == 0) q0.push_back(expect_rsp(pc));
        else         q1.push_back(expect_rsp(pc));
    endtask

    task automatic requester(input int id, input int n, input logic [15:0] first_pc);
        logic [15:0] pc;
        bit          got, abandon;
        for (int i = 0; i < n; i++) begin
            pc = (i == 0) ? first_pc : 16'($urandom);
            if (i % 5 == 1) pc[4:0] = 5'd15;   // completes on the last timer value
            if (i % 5 == 2) pc[4:0] = 5'd16;   // one cycle too late: timeout
            abandon = (i % 7 == 3);
            @(posedge clock); #1;
            drive_req(id, 1'b1, pc);
            got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                @(negedge clock);
                if (get_ready(id)) got = 1'b1;
                else if (abandon) break;
            end
            if (got) push_exp(id, pc);
            else if (!abandon) check("ready_wait_bound", got, 1);
            @(posedge clock); #1;
            drive_req(id, 1'b0, 16'($urandom));
            repeat ($urandom_range(3)) @(posedge clock);
        end
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((q0.size() + q1.size() != 0 || m_busy) && w < 200) begin
            @(posedge clock);
            w++;
        end
        check(name, q0.size() + q1.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_PC"}, PC, 0);
        check({tag, "_instrmem_rd"}, instrmem_rd, 0);
        check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
        check({tag, "_rsp_valid"}, {req0_rsp_valid, req1_rsp_valid}, 0);
        check({tag, "_rsp0"}, {req0_rsp_data, req0_rsp_err}, 0);
        check({tag, "_rsp1"}, {req1_rsp_data, req1_rsp_err}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_pc    = 16'h0;
        req1_pc    = 16'h0;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        // Both requesters start together, so req0 must be served first.
        fork
            requester(0, 40, 16'h3002);
            requester(1, 40, 16'h4000);
        join
        drain("drain_random");

        // Abort a read by reset while in WAIT.
        @(posedge clock); #1;
        req1_pc    = 16'h401F;
        req1_valid = 1'b1;
        @(negedge clock);
        check("abort_req1_ready", req1_ready, 1);
        @(posedge clock); #1;
        req1_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_idle_outputs("abort");
        reset = 1'b0;

        // After reset a simultaneous request goes to req0.
        req0_pc    = 16'h3000;
        req1_pc    = 16'h4000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clock);
        check("post_reset_grant", {req0_ready, req1_ready}, 2'b10);
        if (req0_ready) push_exp(0, req0_pc);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clock);
            if (req1_ready) begin
                push_exp(1, req1_pc);
                break;
            end
        end
        @(posedge clock); #1;
        req1_valid = 1'b0;
        drain("drain_post_reset");

        // Idle stretch with spurious completions from the responder.
        repeat (30) @(posedge clock);
        #1;
        check("idle_no_rd", instrmem_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
